bufor_op: RTL
=============

// Module: bufor_op
// PURPOSE
//  - Elastic output buffer sitting directly downstream of the fixed-latency delay line.
//  - Captures the delay line's N-bit word stream, tagged by a valid bit delayed alongside it, into a small synchronous FIFO.
//  - Offers the words to the consumer over a valid/ready handshake.
//  - Absorbs consumer stalls the delay line cannot see. The delay line has no backpressure, so words arriving while the buffer is full are dropped and flagged.
// PARAMETERS
//  N      2   data word width; must match the upstream delay line width
//  DEPTH  4   FIFO entries; power of two, >=2
//  AW     2   pointer width = log2(DEPTH); set consistently with DEPTH
// PORTS
//  clk       in   1     single clock, rising-edge
//  rst_n     in   1     synchronous reset, active-low
//  idata     in   N     word from the delay line output
//  ivalid    in   1     idata valid this cycle (delayed with the same latency as idata)
//  odata     out  N     head-of-FIFO word
//  ovalid    out  1     odata valid
//  oready    in   1     consumer accepts odata this cycle
//  full      out  1     level==DEPTH
//  empty     out  1     level==0
//  level     out  AW+1  stored word count, 0..DEPTH
//  overflow  out  1     sticky: at least one word dropped since reset
// BEHAVIOUR
//  - Clocking and reset: one clock, clk; reset rst_n is synchronous and active-low. All state is sampled on posedge clk.
//  - Reset values: while rst_n=0 at an edge, set wr_ptr=0, rd_ptr=0, level=0 and overflow=0. Outputs after reset: ovalid=0, empty=1, full=0. odata is don't-care; storage array is not reset.
//  - Reset mid-operation: all stored words are discarded. ivalid and oready are ignored on the reset edge.
//  - Read fires (rd) when ovalid && oready.
//  - Write fires (wr) when ivalid && (!full || rd). A full buffer accepts a word in the same cycle it is read.
//  - Drop occurs when ivalid && full && !rd. The word is lost and overflow is set to 1; overflow stays 1 until reset.
//  - Storage update: on wr, mem[wr_ptr]<=idata and wr_ptr<=wr_ptr+1. On rd, rd_ptr<=rd_ptr+1. Both pointers wrap DEPTH-1 -> 0 (AW-bit natural wrap).
//  - level update, with no over- or underflow possible:
//    - wr && !rd -> level+1
//    - rd && !wr -> level-1
//    - both or neither -> unchanged
//  - Output is first-word-fall-through:
//    - odata = mem[rd_ptr]
//    - ovalid = !empty
//    - full, empty and ovalid decode combinationally from registered level only; no combinational path from ivalid or oready.
//  - Latency: a word written at edge k is presented with ovalid=1 in the cycle after edge k (1 cycle, empty buffer).
//  - Simultaneous read and write while empty: not possible, because ovalid=0 blocks rd. Only the write occurs.
//  - ovalid/odata stay stable while oready=0 (AXI-style hold).
// CONFIGURATION
//  - Macro BUFOR_OP_DROPCNT_EN.
//  - Defined:
//    - Adds output port drop_cnt, width 16: number of dropped words since reset.
//    - Increments by 1 on each drop and saturates at 16'hFFFF.
//    - Reset value 0.
//  - Undefined: port drop_cnt and its counter are absent. All other behaviour is identical; overflow is always present.
// TESTING
//  - Reset, then idle: ovalid=0, empty=1, full=0, level=0, overflow=0.
//  - N=2, DEPTH=4, oready=1. Drive ivalid=1 with idata 1,2,3 on consecutive cycles. Expect odata 1,2,3 each one cycle later; level never exceeds 1.
//  - oready=0, write 5 words 0,1,2,3,0:
//    - After 4 writes: full=1, level=4.
//    - 5th word dropped; overflow=1; drop_cnt=1 when BUFOR_OP_DROPCNT_EN is defined.
//    - Drain with oready=1: reads 0,1,2,3, then empty=1.
//  - Full buffer with ivalid=1, idata=2 and oready=1 in the same cycle: head is read, new word accepted, level stays 4, overflow unchanged.
//  - Pointer wrap: stream 10 words with oready toggling 1,0. Output order matches input order, with no loss.
//  - Reset mid-operation: with level=3, assert rst_n=0 for one edge with ivalid=1. Afterwards level=0, ovalid=0, overflow=0, and the dropped word is not stored.

Source files
------------

// File: rtl/bufor_op.sv
// bufor_op: elastic output buffer behind the fixed-latency delay line.
// The delay line cannot be stalled, so this block holds its words in a small
// first-word-fall-through FIFO with a valid/ready output. Words that arrive
// while the FIFO is full are dropped, and the sticky overflow flag is set.
// Optional feature: define BUFOR_OP_DROPCNT_EN to add drop_cnt, a 16-bit
// saturating count of dropped words.
module bufor_op #(
   parameter int N     = 2,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  idata,
   input  logic          ivalid,
   output logic [N-1:0]  odata,
   output logic          ovalid,
   input  logic          oready,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level,
   output logic          overflow
`ifdef BUFOR_OP_DROPCNT_EN
   ,
   output logic [15:0]   drop_cnt
`endif
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          rd;
   logic          wr;
   logic          drop;

   // Saturating increment for the 16-bit drop counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Flags and handshake decode from registered level only.
   assign empty  = (level == '0);
   assign full   = (level == FULL_LVL);
   assign ovalid = !empty;
   assign odata  = mem[rd_ptr];

   // A full buffer still takes a word when its head leaves in the same cycle.
   assign rd   = ovalid && oready;
   assign wr   = ivalid && (!full || rd);
   assign drop = ivalid && full && !rd;

   // Storage write; the array is not reset, and nothing is stored on a reset edge.
   always_ff @(posedge clk) begin
      if (rst_n && wr) begin
         mem[wr_ptr] <= idata;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         if (wr && !rd)      level <= level + 1'b1;
         else if (rd && !wr) level <= level - 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef BUFOR_OP_DROPCNT_EN
   // Saturating count of dropped words since reset.
   always_ff @(posedge clk) begin
      if (!rst_n)    drop_cnt <= '0;
      else if (drop) drop_cnt <= sat_inc16(drop_cnt);
   end
`endif

endmodule
